// File: rtl/controle_falha_cache_pkg.sv
// Shared types and defaults for the cache miss / write-back controller.
package controle_falha_cache_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned TMO_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Miss context captured at acceptance and held for the whole operation.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [ADDR_W-1:0] vtag;
    logic [DATA_W-1:0] vdata;
  } miss_req_t;

endpackage

// File: rtl/controle_falha_cache_if.sv
// Miss, fill and RAM handshake bundle between cache, controller and RAM.
interface controle_falha_cache_if;
  import controle_falha_cache_pkg::*;

  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_write;
  logic [DATA_W-1:0] miss_wdata;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_tag;
  logic [DATA_W-1:0] victim_data;

  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              fill_dirty;
  logic              fill_err;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic              ram_hit;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  miss_valid, miss_addr, miss_write, miss_wdata,
           victim_dirty, victim_tag, victim_data,
           fill_ready, ram_ack, ram_hit, ram_rdata,
    output miss_ready, fill_valid, fill_addr, fill_data, fill_dirty, fill_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output miss_valid, miss_addr, miss_write, miss_wdata,
           victim_dirty, victim_tag, victim_data,
           fill_ready, ram_ack, ram_hit, ram_rdata,
    input  miss_ready, fill_valid, fill_addr, fill_data, fill_dirty, fill_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/controle_falha_cache_contador_saturado.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module contador_saturado #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/controle_falha_cache.sv
// Miss/write-back controller: optional victim write-back, optional fetch,
// then a held fill response to the cache. All outputs are registered.
module controle_falha_cache
  import controle_falha_cache_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  controle_falha_cache_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     miss_count,
  output logic [CNT_W-1:0]     wb_count
);

  state_e            state_q, state_d;
  miss_req_t         req_q, req_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  logic              miss_ready_q, miss_ready_d;
  logic              busy_q, busy_d;
  logic              fill_valid_q, fill_valid_d;
  logic              fill_err_q, fill_err_d;
  logic              fill_dirty_q, fill_dirty_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic              ack;
  logic              tmo_hit;
  logic              miss_inc;
  logic              wb_inc;

  // Next state, captured context, and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    fill_data_d = fill_data_q;
    miss_inc    = 1'b0;
    wb_inc      = 1'b0;
    ack         = bus.ram_ack & ram_req_q;
    tmo_hit     = (tmo_q == TMO_W'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        if (bus.miss_valid && miss_ready_q) begin
          req_d.addr  = bus.miss_addr;
          req_d.write = bus.miss_write;
          req_d.vtag  = bus.victim_tag;
          req_d.vdata = bus.victim_data;
          fill_data_d = bus.miss_write ? bus.miss_wdata : '0;
          err_d       = 1'b0;
          tmo_d       = '0;
          miss_inc    = 1'b1;
          if (bus.victim_dirty)    state_d = WB;
          else if (!bus.miss_write) state_d = FETCH;
          else                      state_d = RESP;
        end
      end
      WB: begin
        if (ack) begin
          if (bus.ram_hit) wb_inc = 1'b1;
          else             err_d  = 1'b1;
          tmo_d   = '0;
          state_d = req_q.write ? RESP : FETCH;
        end else if (tmo_hit) begin
          // Abandon the write-back and skip the fetch as well.
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FETCH: begin
        if (ack) begin
          fill_data_d = bus.ram_hit ? bus.ram_rdata : '0;
          if (!bus.ram_hit) err_d = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RESP: begin
        if (bus.fill_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    miss_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    ram_req_d    = (state_d == WB) || (state_d == FETCH);
    ram_we_d     = (state_d == WB);
    ram_addr_d   = (state_d == WB)    ? req_d.vtag :
                   (state_d == FETCH) ? req_d.addr : '0;
    ram_wdata_d  = (state_d == WB)    ? req_d.vdata : '0;
    fill_valid_d = (state_d == RESP);
    fill_addr_d  = req_d.addr;
    fill_dirty_d = req_d.write;
    fill_err_d   = (state_d == RESP) && err_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      fill_data_q  <= '0;
      miss_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
      fill_dirty_q <= 1'b0;
      fill_addr_q  <= '0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      fill_data_q  <= fill_data_d;
      miss_ready_q <= miss_ready_d;
      busy_q       <= busy_d;
      fill_valid_q <= fill_valid_d;
      fill_err_q   <= fill_err_d;
      fill_dirty_q <= fill_dirty_d;
      fill_addr_q  <= fill_addr_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  contador_saturado #(.W(CNT_W)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (miss_inc),
    .count_o (miss_count)
  );

  contador_saturado #(.W(CNT_W)) u_wb_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (wb_inc),
    .count_o (wb_count)
  );

  assign bus.miss_ready = miss_ready_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.fill_dirty = fill_dirty_q;
  assign bus.fill_err   = fill_err_q;
  assign bus.ram_req    = ram_req_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_controle_falha_cache.sv
// Randomized bench for controle_falha_cache against a transaction-level model.
module tb_controle_falha_cache;
  import controle_falha_cache_pkg::*;

  localparam int unsigned T = 15;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ram_op_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [7:0] miss_count;
  logic [7:0] wb_count;

  controle_falha_cache_if bus ();

  controle_falha_cache #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM contents seen by the RAM responder, and the model's own copy.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  ram_op_t    op_log  [$];
  ram_op_t    exp_ops [$];

  int   cfg_dwb, cfg_df;
  logic cfg_hwb, cfg_hf;
  logic noise_en;
  int   exp_miss, exp_wb;

  // RAM responder: each phase acks after a configured number of idle cycles.
  bit in_phase = 0;
  int wait_n   = 0;
  always @(negedge clock) begin
    if (bus.ram_req !== 1'b1) begin
      in_phase    = 0;
      bus.ram_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.ram_hit = 1'($urandom_range(0, 1));
      bus.ram_rdata = 8'($urandom);
    end else begin
      if (!in_phase) begin
        in_phase = 1;
        wait_n   = bus.ram_we ? cfg_dwb : cfg_df;
      end
      if (wait_n == 0) begin
        bus.ram_ack   = 1'b1;
        bus.ram_hit   = bus.ram_we ? cfg_hwb : cfg_hf;
        bus.ram_rdata = bus.ram_hit ? mem[bus.ram_addr] : 8'($urandom);
        op_log.push_back({bus.ram_we, bus.ram_addr, bus.ram_we ? bus.ram_wdata : 8'h00});
        if (bus.ram_we && bus.ram_hit) mem[bus.ram_addr] = bus.ram_wdata;
        in_phase = 0;
      end else begin
        bus.ram_ack = 1'b0;
        wait_n--;
      end
    end
  end

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic int pick_delay();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return $urandom_range(0, 3);
      6:                return T - 1;
      7:                return T;
      8:                return T + 10;
      default:          return 1;
    endcase
  endfunction

  // One full miss: drive, predict, check latency, fill fields, RAM traffic, counters.
  task automatic do_miss(input logic [7:0] addr, input logic wr, input logic [7:0] wdata,
                         input logic vd, input logic [7:0] vtag, input logic [7:0] vdata,
                         input int dwb, input logic hwb, input int df, input logic hf,
                         input int stall);
    int         lat, n;
    logic       err, wb_to;
    logic [7:0] data;
    ram_op_t    op;

    err = 1'b0; wb_to = 1'b0; lat = 1;
    exp_ops.delete();
    if (vd) begin
      if (dwb >= int'(T)) begin
        err = 1'b1; wb_to = 1'b1; lat += T;
      end else begin
        lat += dwb + 1;
        exp_ops.push_back({1'b1, vtag, vdata});
        if (hwb) begin
          exp_wb = sat_inc(exp_wb);
          ref_mem[vtag] = vdata;
        end else err = 1'b1;
      end
    end
    data = wr ? wdata : 8'h00;
    if (!wr && !wb_to) begin
      if (df >= int'(T)) begin
        err = 1'b1; lat += T;
      end else begin
        lat += df + 1;
        exp_ops.push_back({1'b0, addr, 8'h00});
        if (hf) data = ref_mem[addr];
        else    err  = 1'b1;
      end
    end
    exp_miss = sat_inc(exp_miss);

    cfg_dwb = dwb; cfg_hwb = hwb; cfg_df = df; cfg_hf = hf;
    op_log.delete();

    @(negedge clock);
    chk("miss_ready_idle", 32'(bus.miss_ready), 32'd1);
    bus.miss_valid   = 1'b1;
    bus.miss_addr    = addr;
    bus.miss_write   = wr;
    bus.miss_wdata   = wdata;
    bus.victim_dirty = vd;
    bus.victim_tag   = vtag;
    bus.victim_data  = vdata;
    @(posedge clock);
    #1 bus.miss_valid = 1'b0;

    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.fill_valid && n < 400);
    chk("latency", 32'(n), 32'(lat));

    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clock);
      chk("fill_valid", 32'(bus.fill_valid), 32'd1);
      chk("fill_addr",  32'(bus.fill_addr),  32'(addr));
      chk("fill_data",  32'(bus.fill_data),  32'(data));
      chk("fill_dirty", 32'(bus.fill_dirty), 32'(wr));
      chk("fill_err",   32'(bus.fill_err),   32'(err));
      chk("busy_resp",  32'(busy),           32'd1);
      chk("ram_req_resp", 32'(bus.ram_req),  32'd0);
    end
    bus.fill_ready = 1'b1;
    @(posedge clock);
    #1 bus.fill_ready = 1'b0;
    @(negedge clock);
    chk("fill_valid_done", 32'(bus.fill_valid), 32'd0);
    chk("busy_done",       32'(busy),           32'd0);
    chk("miss_count",      32'(miss_count),     32'(exp_miss));
    chk("wb_count",        32'(wb_count),       32'(exp_wb));
    chk("ram_op_count",    32'(op_log.size()),  32'(exp_ops.size()));
    for (int i = 0; i < op_log.size() && i < exp_ops.size(); i++) begin
      op = op_log[i];
      chk("ram_op", 32'(op), 32'(exp_ops[i]));
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    noise_en         = 1'b0;
    bus.miss_valid   = 1'b0;
    bus.miss_addr    = '0;
    bus.miss_write   = 1'b0;
    bus.miss_wdata   = '0;
    bus.victim_dirty = 1'b0;
    bus.victim_tag   = '0;
    bus.victim_data  = '0;
    bus.fill_ready   = 1'b0;
    bus.ram_ack      = 1'b0;
    bus.ram_hit      = 1'b0;
    bus.ram_rdata    = '0;
    cfg_dwb = 0; cfg_df = 0; cfg_hwb = 1'b1; cfg_hf = 1'b1;
    exp_miss = 0; exp_wb = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h66] = 8'h01; ref_mem[8'h66] = 8'h01;
    mem[8'h65] = 8'h03; ref_mem[8'h65] = 8'h03;

    repeat (2) @(negedge clock);
    chk("rst_ram_req",    32'(bus.ram_req),    32'd0);
    chk("rst_fill_valid", 32'(bus.fill_valid), 32'd0);
    chk("rst_fill_err",   32'(bus.fill_err),   32'd0);
    chk("rst_busy",       32'(busy),           32'd0);
    chk("rst_miss_count", 32'(miss_count),     32'd0);
    chk("rst_wb_count",   32'(wb_count),       32'd0);
    chk("rst_fill_addr",  32'(bus.fill_addr),  32'd0);
    chk("rst_fill_data",  32'(bus.fill_data),  32'd0);
    chk("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
    chk("rst_miss_ready", 32'(bus.miss_ready), 32'd1);
    reset_n = 1'b1;

    // Directed scenarios.
    do_miss(8'h66, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b1, 0);
    do_miss(8'h65, 1'b0, 8'h00, 1'b1, 8'h04, 8'h07, 0, 1'b1, 0, 1'b1, 0);
    do_miss(8'h67, 1'b1, 8'hAA, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b1, 0);
    do_miss(8'h68, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b1, 200, 1'b1, 0);
    do_miss(8'h69, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b1, 0);
    do_miss(8'h6A, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b0, 0);
    do_miss(8'h6B, 1'b0, 8'h00, 1'b1, 8'h30, 8'h31, T - 1, 1'b1, T - 1, 1'b1, 0);
    do_miss(8'h6C, 1'b1, 8'h55, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b1, 5);

    // Reset in the middle of a write-back.
    cfg_dwb = 100; cfg_hwb = 1'b1;
    @(negedge clock);
    bus.miss_valid   = 1'b1;
    bus.miss_addr    = 8'h70;
    bus.miss_write   = 1'b0;
    bus.victim_dirty = 1'b1;
    bus.victim_tag   = 8'h11;
    bus.victim_data  = 8'h22;
    @(posedge clock);
    #1 bus.miss_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("wb_ram_req",   32'(bus.ram_req),   32'd1);
    chk("wb_ram_we",    32'(bus.ram_we),    32'd1);
    chk("wb_ram_addr",  32'(bus.ram_addr),  32'h11);
    chk("wb_ram_wdata", 32'(bus.ram_wdata), 32'h22);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ram_req",    32'(bus.ram_req),    32'd0);
    chk("arst_fill_valid", 32'(bus.fill_valid), 32'd0);
    chk("arst_busy",       32'(busy),           32'd0);
    chk("arst_miss_count", 32'(miss_count),     32'd0);
    chk("arst_wb_count",   32'(wb_count),       32'd0);
    exp_miss = 0; exp_wb = 0;
    @(negedge clock);
    reset_n = 1'b1;
    do_miss(8'h71, 1'b0, 8'h00, 1'b1, 8'h12, 8'h34, 1, 1'b1, 2, 1'b1, 1);

    // Random traffic with ack noise while the RAM is not being requested.
    noise_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      do_miss(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              pick_delay(), ($urandom_range(0, 4) != 0),
              pick_delay(), ($urandom_range(0, 4) != 0),
              $urandom_range(0, 3));
    end

    // Drive the miss counter into saturation.
    for (int k = 0; k < 300; k++)
      do_miss(8'($urandom), 1'b1, 8'($urandom), 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b1, 0);
    chk("miss_count_sat", 32'(miss_count), 32'hFF);
    do_miss(8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 0, 1'b1, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
